// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP multiplier among NREQ requesters.
// Optional watchdog on the WAIT state: define FPMUL_ARB_TIMEOUT_EN (limit = TIMEOUT cycles).
module fpmul_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*32-1:0]      req_op1,
   input  logic [NREQ*32-1:0]      req_op2,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         resp_valid,
   output logic [31:0]             resp_result,
   output logic                    resp_overflow,
   output logic                    resp_timeout,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    mul_start,
   output logic [31:0]             mul_op1,
   output logic [31:0]             mul_op2,
   input  logic                    mul_done,
   input  logic [31:0]             mul_result,
   input  logic                    mul_overflow
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = GW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_params
      $error("fpmul_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
   end

   state_t        r_state;
   state_t        w_state_nxt;
   logic [GW-1:0] r_rr_ptr;
   logic [GW-1:0] r_grant_id;
   logic [GW-1:0] w_gnt;
   logic          w_any;
   logic          w_grant;
   logic          w_done_ok;
   logic          w_timeout;
   logic          r_rst_q;
   logic [31:0]   r_op1;
   logic [31:0]   r_op2;
   logic [31:0]   r_resp_result;
   logic          r_resp_overflow;
   logic          r_resp_timeout;
   logic [31:0]   w_op1_arr [NREQ];
   logic [31:0]   w_op2_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_op1_arr[i] = req_op1[32*i +: 32];
      assign w_op2_arr[i] = req_op2[32*i +: 32];
   end

   // Requests are held off while reset is asserted and for the cycle after it.
   always_ff @(posedge clk) begin
      r_rst_q <= rst;
   end

   // First pending requester at or above r_rr_ptr, wrapping past NREQ-1.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      logic [CW-1:0] cand;
      w_any = 1'b0;
      w_gnt = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, r_rr_ptr} + CW'(k);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!w_any && req_valid[cand[GW-1:0]]) begin
            w_any = 1'b1;
            w_gnt = cand[GW-1:0];
         end
      end
   end

   assign w_grant = (r_state == S_IDLE) && w_any && !rst && !r_rst_q;

`ifdef FPMUL_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + TW'(1);
      end
   end

   // A nonzero count means this is not the first WAIT cycle, so a stale done is rejected.
   assign w_done_ok = (r_state == S_WAIT) && mul_done && (r_wait_cnt != '0);
   assign w_timeout = (r_state == S_WAIT) && !w_done_ok && (r_wait_cnt == TW'(TIMEOUT - 1));
`else
   logic r_wait_armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_armed <= 1'b0;
      end else if (r_state == S_ISSUE) begin
         r_wait_armed <= 1'b0;
      end else if (r_state == S_WAIT) begin
         r_wait_armed <= 1'b1;
      end
   end

   assign w_done_ok = (r_state == S_WAIT) && mul_done && r_wait_armed;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignment so all flops update together.
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (w_done_ok || w_timeout) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      if (w_grant) begin
         req_ready[w_gnt] = 1'b1;
      end
      if (r_state == S_RESP) begin
         resp_valid[r_grant_id] = 1'b1;
      end
      mul_start = (r_state == S_ISSUE);
      busy      = (r_state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr        <= '0;
         r_grant_id      <= '0;
         r_op1           <= '0;
         r_op2           <= '0;
         r_resp_result   <= '0;
         r_resp_overflow <= 1'b0;
         r_resp_timeout  <= 1'b0;
      end else begin
         if (w_grant) begin
            r_grant_id <= w_gnt;
            r_op1      <= w_op1_arr[w_gnt];
            r_op2      <= w_op2_arr[w_gnt];
         end
         if (w_done_ok) begin
            r_resp_result   <= mul_result;
            r_resp_overflow <= mul_overflow;
            r_resp_timeout  <= 1'b0;
         end else if (w_timeout) begin
            r_resp_result   <= '0;
            r_resp_overflow <= 1'b0;
            r_resp_timeout  <= 1'b1;
         end
         if (r_state == S_RESP) begin
            r_rr_ptr <= (r_grant_id == GW'(NREQ - 1)) ? '0 : r_grant_id + GW'(1);
         end
      end
   end

   assign grant_id      = r_grant_id;
   assign mul_op1       = r_op1;
   assign mul_op2       = r_op2;
   assign resp_result   = r_resp_result;
   assign resp_overflow = r_resp_overflow;
   assign resp_timeout  = r_resp_timeout;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter: cycle-offset transaction model, bench-side
// multiplier with a programmable latency, and directed round-robin/reset/timeout scenarios.
module tb_fpmul_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 8;
`ifdef FPMUL_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*32-1:0] req_op1;
   logic [NREQ*32-1:0] req_op2;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   resp_valid;
   logic [31:0]       resp_result;
   logic              resp_overflow;
   logic              resp_timeout;
   logic [1:0]        grant_id;
   logic              busy;
   logic              mul_start;
   logic [31:0]       mul_op1;
   logic [31:0]       mul_op2;
   logic              mul_done;
   logic [31:0]       mul_result;
   logic              mul_overflow;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int              id;
      logic [NREQ-1:0] mask;
      logic [31:0]     res;
      logic            ovf;
      logic            to;
      int              cyc;
   } resp_t;

   resp_t resp_log[$];
   int    grant_log[$];
   int    grant_cyc[$];
   int    start_count;
   int    cyc;
   int    mul_lat;
   bit    stale_en;

   fpmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
      .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_result(resp_result), .resp_overflow(resp_overflow), .resp_timeout(resp_timeout),
      .grant_id(grant_id), .busy(busy),
      .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2),
      .mul_done(mul_done), .mul_result(mul_result), .mul_overflow(mul_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hand-computed IEEE-754 products: {overflow, result}.
   function automatic logic [32:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3FA0_0000 && b == 32'h3FC0_0000) return {1'b0, 32'h3FF0_0000}; // 1.25*1.5
      if (a == 32'h4000_0000 && b == 32'h4040_0000) return {1'b0, 32'h40C0_0000}; // 2*3
      if (a == 32'h7F00_0000 && b == 32'h7F00_0000) return {1'b1, 32'h7F80_0000}; // overflow
      return 33'h0;
   endfunction

   // Multiplier stand-in: done mul_lat cycles after the start cycle; optional stale
   // done pulse on the first WAIT cycle carrying garbage.
   initial begin : mul_model
      int since;
      logic [32:0] r;
      since        = -1;
      mul_done     = 1'b0;
      mul_result   = '0;
      mul_overflow = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mul_done     = 1'b0;
         mul_result   = '0;
         mul_overflow = 1'b0;
         if (mul_start === 1'b1) since = 0;
         else if (since >= 0) since++;
         if (stale_en && since == 1) begin
            mul_done     = 1'b1;
            mul_result   = 32'hDEAD_BEEF;
            mul_overflow = 1'b1;
         end
         if (mul_lat > 0 && since == mul_lat) begin
            r            = mul_ref(mul_op1, mul_op2);
            mul_done     = 1'b1;
            mul_result   = r[31:0];
            mul_overflow = r[32];
         end
      end
   end

   // Transaction model: outputs follow from the grant cycle, the first accepted done and
   // the watchdog limit, expressed as cycle offsets from the grant.
   initial begin : compare
      bit              m_busy;
      bit              m_rst_prev;
      int              m_g, m_gid, m_rr, m_gc, m_rc, g;
      logic [31:0]     m_op1, m_op2, m_res;
      logic            m_ovf, m_to;
      logic [NREQ-1:0] exp_ready, exp_resp;
      resp_t           e;
      m_busy = 0; m_rst_prev = 1; m_g = 0; m_gid = 0; m_rr = 0; m_gc = 0; m_rc = -1;
      m_op1 = '0; m_op2 = '0; m_res = '0; m_ovf = 1'b0; m_to = 1'b0;
      cyc = 0;
      start_count = 0;
      forever begin
         @(negedge clk);
         cyc++;
         g = -1;
         exp_ready = '0;
         if (!m_busy && rst === 1'b0 && !m_rst_prev) begin
            for (int k = 0; k < NREQ; k++) begin
               if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         exp_resp = '0;
         if (m_busy && cyc == m_rc) exp_resp[m_g] = 1'b1;

         check("req_ready", req_ready, exp_ready);
         check("resp_valid", resp_valid, exp_resp);
         check("mul_start", mul_start, m_busy && (cyc == m_gc + 1));
         check("busy", busy, m_busy);
         check("grant_id", grant_id, m_gid);
         check("mul_op1", mul_op1, m_op1);
         check("mul_op2", mul_op2, m_op2);
         check("resp_result", resp_result, m_res);
         check("resp_overflow", resp_overflow, m_ovf);
         check("resp_timeout", resp_timeout, m_to);

         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1) begin
               grant_log.push_back(i);
               grant_cyc.push_back(cyc);
            end
            if (resp_valid[i] === 1'b1) begin
               e.id = i; e.mask = resp_valid; e.res = resp_result;
               e.ovf = resp_overflow; e.to = resp_timeout; e.cyc = cyc;
               resp_log.push_back(e);
            end
         end
         if (mul_start === 1'b1) start_count++;

         if (g >= 0) begin
            m_busy = 1; m_g = g; m_gid = g; m_gc = cyc; m_rc = -1;
            m_op1 = req_op1[g*32 +: 32];
            m_op2 = req_op2[g*32 +: 32];
         end else if (m_busy) begin
            if (m_rc < 0 && cyc >= m_gc + 3 && mul_done === 1'b1) begin
               m_res = mul_result; m_ovf = mul_overflow; m_to = 1'b0; m_rc = cyc + 1;
            end else if (TO_EN && m_rc < 0 && cyc == m_gc + 1 + TO) begin
               m_res = '0; m_ovf = 1'b0; m_to = 1'b1; m_rc = cyc + 1;
            end else if (cyc == m_rc) begin
               m_busy = 0; m_rr = (m_g + 1) % NREQ;
            end
         end
         m_rst_prev = (rst !== 1'b0);
         if (rst !== 1'b0) begin
            m_busy = 0; m_rr = 0; m_gid = 0; m_rc = -1;
            m_op1 = '0; m_op2 = '0; m_res = '0; m_ovf = 1'b0; m_to = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request_once(input logic [NREQ-1:0] m);
      req_valid = m;
      step();
      req_valid = '0;
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      req_op1[i*32 +: 32] = a;
      req_op2[i*32 +: 32] = b;
   endtask

   task automatic wait_resps(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (resp_log.size() < n && k < budget) begin
         step();
         k++;
      end
      check(name, resp_log.size() >= n, 1);
   endtask

   task automatic wait_grants(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (grant_log.size() < n && k < budget) begin
         step();
         k++;
      end
      check(name, grant_log.size() >= n, 1);
   endtask

   task automatic check_grant(input string name, input int idx, input int exp_id);
      if (idx >= grant_log.size()) check({name, "_present"}, grant_log.size(), idx + 1);
      else check(name, grant_log[idx], exp_id);
   endtask

   task automatic check_resp(input string name, input int idx, input int exp_id,
                             input logic [31:0] exp_res, input logic exp_ovf, input logic exp_to);
      logic [NREQ-1:0] em;
      em = '0;
      em[exp_id] = 1'b1;
      if (idx >= resp_log.size()) begin
         check({name, "_present"}, resp_log.size(), idx + 1);
      end else begin
         check({name, "_mask"}, resp_log[idx].mask, em);
         check({name, "_result"}, resp_log[idx].res, exp_res);
         check({name, "_ovf"}, resp_log[idx].ovf, exp_ovf);
         check({name, "_timeout"}, resp_log[idx].to, exp_to);
      end
   endtask

   task automatic clear_logs();
      resp_log.delete();
      grant_log.delete();
      grant_cyc.delete();
      start_count = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin : stimulus
      int exp_g [5];
      rst       = 1'b1;
      req_valid = '1;
      req_op1   = '0;
      req_op2   = '0;
      mul_lat   = 2;
      stale_en  = 1'b0;

      // 1: reset held three cycles with every requester asserting
      repeat (3) begin
         @(negedge clk);
         check("t1_req_ready", req_ready, 0);
         check("t1_busy_start", {busy, mul_start}, 0);
         check("t1_resp", {resp_valid, resp_result, resp_overflow, resp_timeout}, 0);
         check("t1_ops", {mul_op1, mul_op2}, 0);
      end
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t1_ready_after_rst", req_ready, 0);
      step();
      req_valid = '0;
      step();

      // 2: single request from requester 0
      clear_logs();
      set_ops(0, 32'h3FA0_0000, 32'h3FC0_0000);
      request_once(4'b0001);
      wait_resps(1, 20, "t2_wait");
      check_grant("t2_grant", 0, 0);
      check_resp("t2_resp", 0, 0, 32'h3FF0_0000, 1'b0, 1'b0);
      check("t2_start_pulses", start_count, 1);
      if (resp_log.size() > 0 && grant_cyc.size() > 0)
         check("t2_latency", resp_log[0].cyc - grant_cyc[0], 4);
      step();
      step();

      // 3: round-robin under continuous requests, stale done pulses injected
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      clear_logs();
      for (int i = 0; i < NREQ; i++) set_ops(i, 32'h4000_0000, 32'h4040_0000);
      stale_en  = 1'b1;
      req_valid = 4'b1111;
      wait_grants(5, 60, "t3_wait_grants");
      req_valid = '0;
      wait_resps(5, 40, "t3_wait_resps");
      stale_en = 1'b0;
      exp_g = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         check_grant($sformatf("t3_grant%0d", i), i, exp_g[i]);
         check_resp($sformatf("t3_resp%0d", i), i, exp_g[i], 32'h40C0_0000, 1'b0, 1'b0);
      end
      step();
      step();

      // 4: wrap and skip from rr_ptr=3, then lone requester 3 with overflow
      clear_logs();
      mul_lat = 5;
      set_ops(2, 32'h3FA0_0000, 32'h3FC0_0000);
      set_ops(3, 32'h7F00_0000, 32'h7F00_0000);
      request_once(4'b0100);
      wait_resps(1, 20, "t4_wait_first");
      step();
      req_valid = 4'b0101;
      wait_grants(3, 40, "t4_wait_grants");
      req_valid = '0;
      wait_resps(3, 30, "t4_wait_resps");
      step();
      request_once(4'b1000);
      wait_resps(4, 20, "t4_wait_last");
      check_grant("t4_grant0", 0, 2);
      check_grant("t4_grant1", 1, 0);
      check_grant("t4_grant2", 2, 2);
      check_grant("t4_grant3", 3, 3);
      check_resp("t4_resp1", 1, 0, 32'h40C0_0000, 1'b0, 1'b0);
      check_resp("t4_resp2", 2, 2, 32'h3FF0_0000, 1'b0, 1'b0);
      check_resp("t4_resp3", 3, 3, 32'h7F80_0000, 1'b1, 1'b0);
      step();
      step();

      // 5: reset while waiting; the late product must not surface
      clear_logs();
      mul_lat = 6;
      request_once(4'b0010);
      step();
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      check("t5_no_resp", resp_log.size(), 0);
      check("t5_idle", busy, 1'b0);
      mul_lat = 2;
      request_once(4'b0011);
      wait_resps(1, 20, "t5_wait");
      check_grant("t5_grant0", 0, 1);
      check_grant("t5_grant1", 1, 0);
      check_resp("t5_resp", 0, 0, 32'h40C0_0000, 1'b0, 1'b0);
      step();
      step();

      // 6: missing done
      clear_logs();
`ifdef FPMUL_ARB_TIMEOUT_EN
      mul_lat = TO + 6;
      request_once(4'b0100);
      wait_resps(1, 30, "t6_wait");
      check_resp("t6_resp", 0, 2, 32'h0, 1'b0, 1'b1);
      if (resp_log.size() > 0 && grant_cyc.size() > 0)
         check("t6_latency", resp_log[0].cyc - grant_cyc[0], TO + 2);
      repeat (15) step();
      check("t6_late_done_ignored", resp_log.size(), 1);
      check("t6_idle", busy, 1'b0);
`else
      mul_lat = 40;
      request_once(4'b0100);
      repeat (30) step();
      check("t6_still_waiting", resp_log.size(), 0);
      check("t6_busy", busy, 1'b1);
      wait_resps(1, 30, "t6_wait");
      check_resp("t6_resp", 0, 2, 32'h3FF0_0000, 1'b0, 1'b0);
      if (resp_log.size() > 0 && grant_cyc.size() > 0)
         check("t6_latency", resp_log[0].cyc - grant_cyc[0], 42);
`endif
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpmul_arbiter.md
# fpmul_arbiter

Round-robin arbiter and sequencer that shares one single-precision floating-point multiplier (`multiple`) among NREQ requesters. It accepts one operand pair at a time, pulses the multiplier's start, and waits for done. It then returns the result, with its overflow flag, to the requester that issued it. It sits between the FP client blocks and the multiplier instance; the multiplier's own clock and reset are wired in parallel at the parent level.

## Interface

**Parameters**

- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: WAIT-state cycle limit. Used only when `FPMUL_ARB_TIMEOUT_EN` is defined.

**Ports**

- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: per-requester request.
- `req_op1` in NREQ*32: packed IEEE-754 operand 1; requester i occupies bits [32i+31:32i].
- `req_op2` in NREQ*32: packed operand 2, same packing.
- `req_ready` out NREQ: one-hot accept strobe.
- `resp_valid` out NREQ: one-hot, one-cycle response strobe.
- `resp_result` out 32: product, shared by all requesters.
- `resp_overflow` out 1: multiplier overflow flag.
- `resp_timeout` out 1: operation aborted by the watchdog.
- `grant_id` out $clog2(NREQ): index of the current or last granted requester.
- `busy` out 1: high whenever the state is not IDLE.
- `mul_start` out 1: start pulse to the multiplier.
- `mul_op1` out 32: operand 1 to the multiplier.
- `mul_op2` out 32: operand 2 to the multiplier.
- `mul_done` in 1: completion from the multiplier.
- `mul_result` in 32: product from the multiplier.
- `mul_overflow` in 1: overflow from the multiplier.

## Operation

**States:** IDLE, ISSUE, WAIT, RESP (2-bit encoding).

**IDLE**
- If any `req_valid` is high, grant the first set bit found searching upward from `rr_ptr` with wrap (`rr_ptr`, `rr_ptr`+1, …, NREQ-1, 0, …).
- In the same cycle:
  - drive `req_ready[g]`=1 (combinational on state and `req_valid`);
  - latch that requester's `req_op1`/`req_op2` into operand registers;
  - set `grant_id`=g;
  - go to ISSUE.
- With no request, stay in IDLE.

**ISSUE**
- `mul_start`=1 for exactly this cycle.
- Clear the wait counter.
- Go to WAIT.

**WAIT**
- Count cycles.
- `mul_done` is ignored on the first WAIT cycle, so a stale done from the previous op is rejected. The multiplier's minimum latency is 2 cycles.
- From the second WAIT cycle on, `mul_done`=1 captures `mul_result` and `mul_overflow` into the response registers; go to RESP.

**RESP**
- `resp_valid[grant_id]`=1 for one cycle, with `resp_result`, `resp_overflow` and `resp_timeout` valid.
- Set `rr_ptr` = (`grant_id`+1) mod NREQ.
- Go to IDLE.

**Operands and data rules**
- `mul_op1`/`mul_op2` are driven from the operand registers. They are stable from ISSUE through RESP and hold their last value in IDLE.
- `resp_result`/`resp_overflow`/`resp_timeout` hold their last captured values until the next RESP.
- Responses have no backpressure: a requester must be able to take `resp_valid` on any cycle.
- A requester deasserting `req_valid` before it is granted is legal. Nothing is latched for it.
- Requests arriving while `busy` are not accepted; `req_ready`=0 outside IDLE.
- `mul_done` outside WAIT is ignored.
- The block performs no arithmetic on the data; operands and results pass bit-exact.

**Reset**
- Values while `rst`, and the cycle after it deasserts:
  - state IDLE, `rr_ptr`=0, `grant_id`=0;
  - `req_ready`=0, `resp_valid`=0, `mul_start`=0, `busy`=0;
  - `resp_result`=0, `resp_overflow`=0, `resp_timeout`=0, `mul_op1`=0, `mul_op2`=0.
- Reset mid-operation discards the in-flight product. No response is ever issued for it.

## Timing

- Request granted in cycle T (`req_ready` high): `mul_start` at T+1, WAIT begins at T+2.
- If `mul_done` is first sampled high in cycle W (W ≥ T+3): `resp_valid` at W+1, IDLE at W+2, next grant possible at W+2.
- Minimum accept-to-response latency: 4 cycles.
- Back-to-back: a requester still holding `req_valid` is skipped if another requester is pending (round-robin fairness).

## Configuration

`FPMUL_ARB_TIMEOUT_EN`

**Defined**
- If WAIT lasts `TIMEOUT` cycles with no accepted `mul_done`, go to RESP with `resp_timeout`=1, `resp_result`=0, `resp_overflow`=0.
- A late `mul_done` after a timeout is ignored.

**Not defined**
- No counter logic; WAIT waits indefinitely.
- `resp_timeout` is tied 0.

## Test plan

1. **Reset:** hold `rst` 3 cycles with `req_valid`=4'b1111 → every output 0, `req_ready`=0 throughout.
2. **Single request:** req0 with op1=0x3FA00000, op2=0x3FC00000 → one `mul_start` pulse, `resp_valid`=4'b0001, `resp_result`=0x3FF00000, `resp_overflow`=0.
3. **Round-robin:** `req_valid`=4'b1111 held continuously with products 2×3 on all four requesters → grants in order 0,1,2,3,0, each `resp_result`=0x40C00000.
4. **Wrap and skip:** `rr_ptr`=3, `req_valid`=4'b0101 → grant 0, then 2; `req_valid`=4'b1000 alone → grant 3.
5. **Reset mid-WAIT:** reset during WAIT, then `mul_done` arrives → no `resp_valid`; the next request is granted to requester 0.
6. **Timeout (macro defined, TIMEOUT=8):** no `mul_done` → `resp_valid` 8 WAIT cycles later with `resp_timeout`=1, `resp_result`=0; a later `mul_done` produces nothing.
